// File: rtl/gray_cnt_pkg.sv
// gray_cnt_pkg: shared Gray/binary conversions and counter mode encodings.
// Rev 1.0 - initial release.
`default_nettype none

package gray_cnt_pkg;

  // Widest counter the conversion helpers handle; callers zero-extend and slice.
  localparam int GRAY_MAX_W = 64;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_step_chk.sv
// gray_step_chk: sticky flag raised when consecutive Gray values differ in more than one bit.
// Rev 1.0 - initial release.
`default_nettype none

module gray_step_chk #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] RST_GRAY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] gray,
  output logic             err
);

  logic [WIDTH-1:0] gray_prev;
  logic             load_prev;
  logic [WIDTH-1:0] diff;
  int unsigned      flips;
  logic             multi_flip;

  always_comb begin
    diff  = gray ^ gray_prev;
    flips = 0;
    for (int i = 0; i < WIDTH; i++) begin
      flips = flips + 32'(diff[i]);
    end
    // The value that follows a load is allowed to jump arbitrarily.
    multi_flip = (flips > 1) && !load_prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_prev <= RST_GRAY;
      load_prev <= 1'b0;
      err       <= 1'b0;
    end else begin
      gray_prev <= gray;
      load_prev <= load;
      if (multi_flip) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_counter_param.sv
// gray_counter_param: up/down Gray counter with load, wrap or saturate, coherent bin/gray outputs.
// Optional GRAY_CNT_CHECK_EN adds a single-bit-step checker driving output err.
`default_nettype none

module gray_counter_param
  import gray_cnt_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               SAT_MODE = MODE_WRAP,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             limit
`ifdef GRAY_CNT_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [GRAY_MAX_W-1:0] RST_GRAY_EXT = bin2gray(GRAY_MAX_W'(RST_VAL));
  localparam logic [WIDTH-1:0]      RST_GRAY     = RST_GRAY_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0]      MAX_VAL      = '1;

  logic             at_limit;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;

  always_comb begin
    at_limit = en && !load && ((up && (bin == MAX_VAL)) || (!up && (bin == '0)));
    next_bin = bin;
    if (load) begin
      next_bin = load_val;
    end else if (en) begin
      if (at_limit && (SAT_MODE == MODE_SAT)) begin
        next_bin = bin;
      end else if (up) begin
        next_bin = bin + 1'b1;
      end else begin
        next_bin = bin - 1'b1;
      end
    end
    // Gray comes from the next binary value so both outputs update on the same edge.
    next_gray = next_bin ^ (next_bin >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin   <= RST_VAL;
      gray  <= RST_GRAY;
      limit <= 1'b0;
    end else begin
      bin   <= next_bin;
      gray  <= next_gray;
      limit <= at_limit;
    end
  end

`ifdef GRAY_CNT_CHECK_EN
  gray_step_chk #(
    .WIDTH    (WIDTH),
    .RST_GRAY (RST_GRAY)
  ) u_step_chk (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .gray (gray),
    .err  (err)
  );
`endif

endmodule

`default_nettype wire
